// File: rtl/reg_file_sb.sv
// Register file with registered read ports, same-edge write bypass, optional
// hardwired zero register and a per-register busy scoreboard for RAW hazards.

module reg_file_sb_rd_port #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  enable,
    input  logic [ADDR_W-1:0]                     addr,
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]    regs,
    input  logic                                  reg_w,
    input  logic [ADDR_W-1:0]                     rd,
    input  logic [DATA_W-1:0]                     write_data,
    output logic [DATA_W-1:0]                     data
);
    // Zero check comes before bypass so a write to r0 never leaks through.
    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
        end else if (enable) begin
            if (ZERO_REG != 0 && addr == '0)
                data <= '0;
            else if (reg_w && rd == addr)
                data <= write_data;
            else
                data <= regs[addr];
        end
    end
endmodule

module reg_file_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] R1,
    input  logic [ADDR_W-1:0] R2,
    input  logic [ADDR_W-1:0] inr,
    input  logic [ADDR_W-1:0] RD,
    input  logic              RegW,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    output logic [DATA_W-1:0] RO1,
    output logic [DATA_W-1:0] RO2,
    output logic [DATA_W-1:0] outvalue,
    output logic              busy1,
    output logic              busy2
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic [DEPTH-1:0]             busy;
    logic [2:0][ADDR_W-1:0]       rd_addr;
    logic [2:0][DATA_W-1:0]       rd_data;
    logic                         wr_en;

    assign wr_en = enable && RegW && !(ZERO_REG != 0 && RD == '0);

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_reg
            always_ff @(posedge clk) begin
                if (reset)
                    regs[i] <= '0;
                else if (wr_en && RD == ADDR_W'(i))
                    regs[i] <= WriteData;
            end

            // A new producer (set) outranks the retiring one (clear).
            always_ff @(posedge clk) begin
                if (reset)
                    busy[i] <= 1'b0;
                else if (enable) begin
                    if (sb_set && sb_addr == ADDR_W'(i) && !(ZERO_REG != 0 && i == 0))
                        busy[i] <= 1'b1;
                    else if (RegW && RD == ADDR_W'(i))
                        busy[i] <= 1'b0;
                end
            end
        end
    endgenerate

    assign rd_addr = {inr, R2, R1};

    genvar p;
    generate
        for (p = 0; p < 3; p++) begin : g_port
            reg_file_sb_rd_port #(
                .DATA_W  (DATA_W),
                .ADDR_W  (ADDR_W),
                .ZERO_REG(ZERO_REG)
            ) u_port (
                .clk       (clk),
                .reset     (reset),
                .enable    (enable),
                .addr      (rd_addr[p]),
                .regs      (regs),
                .reg_w     (RegW),
                .rd        (RD),
                .write_data(WriteData),
                .data      (rd_data[p])
            );
        end
    endgenerate

    assign RO1      = rd_data[0];
    assign RO2      = rd_data[1];
    assign outvalue = rd_data[2];

    // Writeback in flight this cycle clears the hazard without waiting a cycle.
    always_comb begin
        busy1 = busy[R1] && !(RegW && enable && RD == R1);
        busy2 = busy[R2] && !(RegW && enable && RD == R2);
        if (ZERO_REG != 0 && R1 == '0) busy1 = 1'b0;
        if (ZERO_REG != 0 && R2 == '0) busy2 = 1'b0;
    end
endmodule
